mac_sequencer: RTL
==================

# mac_sequencer

Upstream/downstream controller for a single `Mac` accumulator cell.
- Accepts a dot-product job as a valid/ready stream of operand pairs, the final pair flagged `in_last`.
- Drives the Mac's `A`, `B`, `reset` and `keep` inputs cycle by cycle.
- Presents the finished accumulator value on a valid/ready result port.
- Sits between the operand fetch logic and one Mac; a parent wrapper wires the two together.

## Interface
Parameters:
- `OP_WIDTH`, 8, operand width (must match the Mac).
- `ACC_WIDTH`, 32, accumulator width (must match the Mac).
- `LEN_WIDTH`, 8, beat-counter width; a job holds at most 2^LEN_WIDTH−1 beats.

Ports (reset reset, synchronous, active-high; clock clk):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  sequencer accepts a beat.
- `in_a`  in  OP_WIDTH  operand A.
- `in_b`  in  OP_WIDTH  operand B.
- `in_last`  in  1  final beat of the job.
- `mac_a`  out  OP_WIDTH  to Mac `A`.
- `mac_b`  out  OP_WIDTH  to Mac `B`.
- `mac_reset`  out  1  to Mac `reset`.
- `mac_keep`  out  1  to Mac `keep`.
- `mac_c`  in  ACC_WIDTH  from Mac `C`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  ACC_WIDTH  dot-product result.
- `out_len`  out  LEN_WIDTH  beats accumulated in this job.
- `out_trunc`  out  1  job was force-ended at the beat limit.

## Operation
- **FSM states:** CLEAR, RUN, FLUSH, OUT. Reset state is CLEAR.
- **CLEAR** (one cycle)
  - Registered `mac_reset`=1, `mac_keep`=1, `in_ready`=0, beat counter := 0.
  - Next state: RUN.
- **RUN**
  - `in_ready`=1.
  - On a handshake: next cycle `mac_a`/`mac_b` = `in_a`/`in_b`, `mac_keep`=0; counter += 1.
  - Cycle without a handshake: next cycle `mac_keep`=1 and `mac_a`/`mac_b` hold their values.
  - Leave RUN when a beat is accepted with `in_last`=1, or when the accepted beat brings the counter to all-ones. In the second case `out_trunc` := 1.
  - Next state: FLUSH.
- **FLUSH** (one cycle)
  - `in_ready`=0; the Mac absorbs the last pair (`mac_keep`=0 this cycle).
  - Next state: OUT.
- **OUT**
  - `mac_keep`=1, `out_valid`=1, `out_data` = `mac_c` (combinational pass-through; the accumulator is frozen by `keep`).
  - `out_len` and `out_trunc` are registered.
  - On `out_valid & out_ready`: next state CLEAR, and `out_trunc` is cleared.
- **Arithmetic:** performed only in the Mac. `out_len` counts accepted beats and never wraps because the limit forces the job end.
- **Back-to-back jobs:** the first beat of a new job can be accepted 2 cycles after the result handshake (OUT→CLEAR→RUN).
- **Reset values** (applied to registered outputs during `reset`):
  - `mac_reset`=1, `mac_keep`=1.
  - `mac_a`=`mac_b`=0.
  - `in_ready`=0, `out_valid`=0, `out_len`=0, `out_trunc`=0.
- **Reset mid-job:** the job is discarded, no result is emitted, and a fresh CLEAR follows.
- **`in_last` with `in_valid`=0:** ignored.

## Timing
- All outputs are registered except `out_data`.
- Last beat accepted at cycle t:
  - Mac operands applied at t+1.
  - `mac_c` final at t+2.
  - `out_valid`=1 at t+2.
- Throughput: one beat per cycle in RUN.
- `mac_keep`=0 only in the cycle after an accepted beat, so exactly one accumulation occurs per accepted beat.
- `out_data`, `out_len` and `out_trunc` stay stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `tpu_pkg`:
  - state enum `mac_seq_state_t` (CLEAR, RUN, FLUSH, OUT);
  - default width constants `OP_WIDTH_DEF`=8, `ACC_WIDTH_DEF`=32.
- No sub-module: FSM, beat counter and operand registers live in one module.
- The Mac is instantiated alongside this block by the parent `mac_unit`, not inside it.

## Test plan
Defaults unless stated: OP_WIDTH=8, ACC_WIDTH=32.
- **Basic job:** beats (3,4), (5,6, last) back-to-back → `out_data`=42, `out_len`=2, `out_trunc`=0, `out_valid` exactly 2 cycles after the last accept.
- **Bubbles and max operands:** beats (255,255), gap of 3 idle cycles, (1,1, last) → `out_data`=65026; `mac_keep`=1 in every bubble cycle.
- **Backpressure:** `out_ready`=0 for 5 cycles in OUT → `out_data`/`out_len` stable, `in_ready`=0. Then assert `out_ready`, run job (2,2, last) → `out_data`=4 (accumulator cleared between jobs).
- **Truncation (LEN_WIDTH=3):** 8 beats of (1,1), none flagged last → job ends after 7 beats; `out_data`=7, `out_len`=7, `out_trunc`=1. The 8th beat is accepted as the first beat of the next job.
- **Reset mid-job:** accept (10,10), assert `reset` for one cycle → `out_valid`=0 and `mac_reset`=1 during reset. Then job (1,2, last) → `out_data`=2.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and default widths for the TPU datapath blocks.
package tpu_pkg;

    // Sequencer control states for a single Mac cell.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } mac_seq_state_t;

    localparam int unsigned OP_WIDTH_DEF  = 8;
    localparam int unsigned ACC_WIDTH_DEF = 32;

endpackage

// File: rtl/mac_sequencer.sv
// mac_sequencer: feeds a stream of operand pairs into one Mac accumulator cell
// and presents the finished dot product on a valid/ready result port.
// The Mac itself lives beside this block in the parent mac_unit.
module mac_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned OP_WIDTH  = OP_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    // operand beat stream
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_a,
    input  logic [OP_WIDTH-1:0]  in_b,
    input  logic                 in_last,
    // Mac control
    output logic [OP_WIDTH-1:0]  mac_a,
    output logic [OP_WIDTH-1:0]  mac_b,
    output logic                 mac_reset,
    output logic                 mac_keep,
    input  logic [ACC_WIDTH-1:0] mac_c,
    // result stream
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [LEN_WIDTH-1:0] out_len,
    output logic                 out_trunc
);

    mac_seq_state_t       state;
    mac_seq_state_t       state_nxt;
    logic                 accept;
    logic [LEN_WIDTH-1:0] len_inc;
    logic                 at_limit;
    logic                 job_end;

    // in_ready is only ever high in RUN, so a handshake implies RUN.
    assign accept   = in_valid & in_ready;
    assign len_inc  = out_len + LEN_WIDTH'(1);
    assign at_limit = (len_inc == '1);
    assign job_end  = accept & (in_last | at_limit);

    // Accumulator is frozen by mac_keep during OUT, so pass it straight through.
    assign out_data = mac_c;

    // Next-state selection for the job control FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   state_nxt = RUN;
            RUN:     if (job_end) state_nxt = FLUSH;
            FLUSH:   state_nxt = OUT;
            OUT:     if (out_valid && out_ready) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // State, registered handshake/Mac controls, beat counter and truncation flag.
    // Control outputs are decoded from the next state so they are registered yet
    // already correct in the first cycle of each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            mac_reset <= 1'b1;
            mac_keep  <= 1'b1;
            mac_a     <= '0;
            mac_b     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_len   <= '0;
            out_trunc <= 1'b0;
        end else begin
            state     <= state_nxt;
            mac_reset <= (state_nxt == CLEAR);
            in_ready  <= (state_nxt == RUN);
            out_valid <= (state_nxt == OUT);
            // exactly one accumulation per accepted beat
            mac_keep  <= ~accept;
            if (accept) begin
                mac_a <= in_a;
                mac_b <= in_b;
            end
            if (state == CLEAR) begin
                out_len <= '0;
            end else if (accept) begin
                out_len <= len_inc;
            end
            if (accept && at_limit && !in_last) begin
                out_trunc <= 1'b1;
            end else if (state == OUT && out_ready) begin
                out_trunc <= 1'b0;
            end
        end
    end

endmodule
